password_lock: RTL and testbench
================================

# password_lock

Sequential multi-digit password lock: the parametrised successor of the single-shot 3-bit checker. It accepts a stream of DIGIT_W-bit digits through a valid/ready handshake and compares a LEN-digit entry against a stored password. It reports success or failure with one-cycle pulses, counts consecutive failures, and enforces a timed lockout after MAX_FAIL failures. It sits behind the switch/button debounce front end and drives the status LEDs.

## Interface

- DIGIT_W, 3: bits per digit.
- LEN, 4: digits per password, at least 1.
- PASSWORD, 12'o5273: LEN*DIGIT_W bits. The first digit entered is compared against the most-significant digit.
- MAX_FAIL, 3: consecutive failures that trigger lockout, at least 1.
- LOCK_CYCLES, 100_000_000: lockout duration in clk cycles, at least 1.
- TIMEOUT_CYCLES, 500_000_000: inter-digit timeout. Used only with PWD_TIMEOUT_EN.

Ports:

- clk, input, 1: system clock. All logic runs on its rising edge.
- rst_n, input, 1: synchronous, active-low reset.
- digit_in, input, DIGIT_W: digit value.
- digit_valid, input, 1: digit_in is valid this cycle.
- digit_ready, output, 1: block can accept a digit. Combinational from state.
- clear, input, 1: abort the partial entry.
- match, output, 1: one-cycle pulse, correct password.
- fail, output, 1: one-cycle pulse, wrong password.
- locked_out, output, 1: level, high during lockout.
- fail_cnt, output, $clog2(MAX_FAIL+1): consecutive failure count.
- digit_cnt, output, $clog2(LEN+1): digits accepted in the current entry.

## Operation

- States:
  - IDLE: no digits entered.
  - ENTRY: 1 to LEN-1 digits entered.
  - CHECK: one cycle, result being registered.
  - LOCKOUT: timed lockout.
- Reset state is IDLE. Reset values: match=0, fail=0, locked_out=0, fail_cnt=0, digit_cnt=0, internal mismatch flag=0. digit_ready is 1 after reset.
- digit_ready=1 in IDLE and ENTRY, and 0 in CHECK and LOCKOUT.
- A digit is accepted on an edge where digit_valid and digit_ready are both high. digit_valid while digit_ready=0 is ignored; no buffering.
- Each accepted digit is compared to PASSWORD digit [digit_cnt], and any mismatch sets a sticky mismatch flag. There is no early abort: all LEN digits are always collected.
- Transitions:
  - IDLE to ENTRY on the first accepted digit, or directly to CHECK when LEN=1.
  - ENTRY to CHECK on accepting the LEN-th digit.
- CHECK resolves as follows:
  - Flag clear: match pulses, fail_cnt is set to 0, next state IDLE.
  - Flag set and fail_cnt+1 < MAX_FAIL: fail pulses, fail_cnt increments, next state IDLE.
  - Flag set and fail_cnt+1 = MAX_FAIL: fail pulses, fail_cnt becomes MAX_FAIL, next state LOCKOUT.
  - digit_cnt and the mismatch flag clear in every case.
- LOCKOUT loads a down-counter with LOCK_CYCLES-1. On reaching 0 it goes to IDLE and sets fail_cnt to 0. All inputs are ignored during lockout.
- clear in IDLE or ENTRY returns to IDLE, zeroes digit_cnt and the flag, and does not count as a failure.
- clear together with an accepted digit: clear wins and the digit is discarded.
- clear in CHECK or LOCKOUT is ignored.
- rst_n low in any state, including mid-entry and mid-lockout, forces reset values on the next edge.

## Timing

- Let edge E accept the last digit.
  - Cycle after E: state CHECK, digit_ready=0.
  - Edge E+1: match or fail rises for exactly one cycle. locked_out rises on the same edge if lockout is triggered.
- locked_out stays high for exactly LOCK_CYCLES cycles. digit_ready returns to 1 in the cycle it falls.
- Back-to-back entry: a new digit can be accepted on edge E+2.
- fail_cnt and digit_cnt update on the same edge as the event that changes them.

## Configuration

- PWD_TIMEOUT_EN defined:
  - In ENTRY, an idle counter reloads on every accepted digit.
  - If TIMEOUT_CYCLES cycles pass with no accepted digit, the entry resolves through CHECK as a failure (fail pulse, fail_cnt increments, lockout rules apply).
  - clear also reloads the counter.
- PWD_TIMEOUT_EN undefined:
  - No timer logic is built, and TIMEOUT_CYCLES is ignored.
  - ENTRY waits indefinitely.

## Test plan

Defaults unless stated, with LOCK_CYCLES=16 and TIMEOUT_CYCLES=32.

- Reset, then enter 5,2,7,3 back-to-back -> match pulses one cycle after the 4th digit is accepted; fail_cnt=0; digit_ready low for exactly 1 cycle.
- Enter 5,2,7,4 -> fail pulses and fail_cnt=1. Then enter 5,2,7,3 -> match pulses and fail_cnt=0.
- Three wrong entries -> locked_out=1 for exactly 16 cycles; digits driven meanwhile are ignored; afterwards fail_cnt=0 and 5,2,7,3 gives match.
- Enter 5,2, then assert clear together with digit 7 -> digit_cnt=0 and no fail. Then 5,2,7,3 -> match.
- Assert rst_n=0 mid-entry and again mid-lockout -> all outputs return to reset values on the next edge; digit_ready=1.
- With PWD_TIMEOUT_EN: enter 5, then wait 32 idle cycles -> fail pulses and fail_cnt=1. Without the macro, the same stimulus gives no fail and digit_cnt=1.

Source files
------------

// File: rtl/password_lock.sv
`default_nettype none
// ============================================================================
// Module   : password_lock
// Purpose  : Sequential multi-digit password lock. Digits arrive one at a time
//            over a valid/ready handshake. A LEN-digit entry is compared
//            against PASSWORD (first digit = most-significant digit). Success
//            or failure is reported with one-cycle pulses. Consecutive
//            failures are counted, and MAX_FAIL failures in a row start a
//            timed lockout of LOCK_CYCLES cycles.
// Ports    : clk         - system clock, rising edge
//            rst_n       - synchronous active-low reset
//            digit_in    - digit value (DIGIT_W bits)
//            digit_valid - digit_in valid this cycle
//            digit_ready - a digit can be accepted (decoded from state)
//            clear       - abort the partial entry (IDLE/ENTRY only)
//            match       - one-cycle pulse, correct password
//            fail        - one-cycle pulse, wrong password
//            locked_out  - level, high for the whole lockout
//            fail_cnt    - consecutive failure count
//            digit_cnt   - digits accepted in the current entry
// Options  : PWD_TIMEOUT_EN - when defined, an entry that sits idle in ENTRY
//            for TIMEOUT_CYCLES cycles resolves as a failure. When undefined
//            no timer is built and TIMEOUT_CYCLES is unused.
// Revision : 1.0 - initial release
// ============================================================================
module password_lock #(
    parameter int                          DIGIT_W        = 3,
    parameter int                          LEN            = 4,
    parameter logic [LEN*DIGIT_W-1:0]      PASSWORD       = 12'o5273,
    parameter int                          MAX_FAIL       = 3,
    parameter int                          LOCK_CYCLES    = 100_000_000,
    parameter int                          TIMEOUT_CYCLES = 500_000_000
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [DIGIT_W-1:0]              digit_in,
    input  logic                            digit_valid,
    output logic                            digit_ready,
    input  logic                            clear,
    output logic                            match,
    output logic                            fail,
    output logic                            locked_out,
    output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt,
    output logic [$clog2(LEN+1)-1:0]        digit_cnt
);

    localparam int c_fc_w   = $clog2(MAX_FAIL+1);
    localparam int c_dc_w   = $clog2(LEN+1);
    localparam int c_pw_w   = LEN*DIGIT_W;
    // A one-cycle lockout still needs a 1-bit counter.
    localparam int c_lcnt_w = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ENTRY   = 2'd1,
        S_CHECK   = 2'd2,
        S_LOCKOUT = 2'd3
    } state_t;

    state_t                r_state,     w_state_nxt;
    logic [c_dc_w-1:0]     r_digit_cnt, w_digit_cnt_nxt;
    logic                  r_mismatch,  w_mismatch_nxt;
    logic [c_fc_w-1:0]     r_fail_cnt,  w_fail_cnt_nxt;
    logic                  r_match,     w_match_nxt;
    logic                  r_fail,      w_fail_nxt;
    logic [c_lcnt_w-1:0]   r_lock_cnt,  w_lock_cnt_nxt;

    logic                  w_ready;
    logic                  w_accept;
    logic                  w_timeout;
    logic [c_pw_w-1:0]     w_pwd_shift;
    logic [DIGIT_W-1:0]    w_exp_digit;

    assign w_ready  = (r_state == S_IDLE) || (r_state == S_ENTRY);
    assign w_accept = digit_valid && w_ready;

    // Shift the wanted digit into the top slot so the first entered digit
    // lines up with the most-significant digit of PASSWORD.
    assign w_pwd_shift = PASSWORD << (r_digit_cnt * DIGIT_W);
    assign w_exp_digit = w_pwd_shift[c_pw_w-1 -: DIGIT_W];

`ifdef PWD_TIMEOUT_EN
    localparam int c_tcnt_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [c_tcnt_w-1:0]   r_idle_cnt, w_idle_cnt_nxt;

    // Reloaded by every accepted digit or clear; counts down only in ENTRY.
    always_comb begin
        w_idle_cnt_nxt = r_idle_cnt;
        if (w_ready && (digit_valid || clear)) begin
            w_idle_cnt_nxt = c_tcnt_w'(TIMEOUT_CYCLES - 1);
        end else if ((r_state == S_ENTRY) && (r_idle_cnt != '0)) begin
            w_idle_cnt_nxt = r_idle_cnt - c_tcnt_w'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= w_idle_cnt_nxt;
        end
    end

    assign w_timeout = (r_state == S_ENTRY) && (r_idle_cnt == '0);
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_digit_cnt_nxt = r_digit_cnt;
        w_mismatch_nxt  = r_mismatch;
        w_fail_cnt_nxt  = r_fail_cnt;
        w_match_nxt     = 1'b0;
        w_fail_nxt      = 1'b0;
        w_lock_cnt_nxt  = r_lock_cnt;

        unique case (r_state)
            S_IDLE, S_ENTRY: begin
                if (clear) begin
                    // clear beats a simultaneous digit, which is discarded.
                    w_state_nxt     = S_IDLE;
                    w_digit_cnt_nxt = '0;
                    w_mismatch_nxt  = 1'b0;
                end else if (w_accept) begin
                    // No early abort: the sticky flag records any wrong digit
                    // while the full entry is still collected.
                    w_digit_cnt_nxt = r_digit_cnt + c_dc_w'(1);
                    w_mismatch_nxt  = r_mismatch || (digit_in != w_exp_digit);
                    if (r_digit_cnt == c_dc_w'(LEN - 1)) begin
                        w_state_nxt = S_CHECK;
                    end else begin
                        w_state_nxt = S_ENTRY;
                    end
                end else if (w_timeout) begin
                    w_state_nxt    = S_CHECK;
                    w_mismatch_nxt = 1'b1;
                end
            end

            S_CHECK: begin
                w_digit_cnt_nxt = '0;
                w_mismatch_nxt  = 1'b0;
                if (!r_mismatch) begin
                    w_match_nxt    = 1'b1;
                    w_fail_cnt_nxt = '0;
                    w_state_nxt    = S_IDLE;
                end else if (r_fail_cnt == c_fc_w'(MAX_FAIL - 1)) begin
                    w_fail_nxt     = 1'b1;
                    w_fail_cnt_nxt = c_fc_w'(MAX_FAIL);
                    w_lock_cnt_nxt = c_lcnt_w'(LOCK_CYCLES - 1);
                    w_state_nxt    = S_LOCKOUT;
                end else begin
                    w_fail_nxt     = 1'b1;
                    w_fail_cnt_nxt = r_fail_cnt + c_fc_w'(1);
                    w_state_nxt    = S_IDLE;
                end
            end

            S_LOCKOUT: begin
                // Counter spans LOCK_CYCLES-1 down to 0: exactly LOCK_CYCLES
                // cycles spent here.
                if (r_lock_cnt == '0) begin
                    w_state_nxt    = S_IDLE;
                    w_fail_cnt_nxt = '0;
                end else begin
                    w_lock_cnt_nxt = r_lock_cnt - c_lcnt_w'(1);
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_digit_cnt <= '0;
            r_mismatch  <= 1'b0;
            r_fail_cnt  <= '0;
            r_match     <= 1'b0;
            r_fail      <= 1'b0;
            r_lock_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_digit_cnt <= w_digit_cnt_nxt;
            r_mismatch  <= w_mismatch_nxt;
            r_fail_cnt  <= w_fail_cnt_nxt;
            r_match     <= w_match_nxt;
            r_fail      <= w_fail_nxt;
            r_lock_cnt  <= w_lock_cnt_nxt;
        end
    end

    assign digit_ready = w_ready;
    assign match       = r_match;
    assign fail        = r_fail;
    assign locked_out  = (r_state == S_LOCKOUT);
    assign fail_cnt    = r_fail_cnt;
    assign digit_cnt   = r_digit_cnt;

endmodule
`default_nettype wire

// File: tb/tb_password_lock.sv
`default_nettype none
// ============================================================================
// Module   : tb_password_lock
// Purpose  : Self-checking bench for password_lock (LOCK_CYCLES=16,
//            TIMEOUT_CYCLES=32). Stimulus pushes the expected result pulse
//            (kind, fail count, arrival cycle) into a queue; a monitor pops
//            and compares whenever match or fail is high.
// Revision : 1.0 - initial release
// ============================================================================
module tb_password_lock;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] digit_in;
    logic       digit_valid;
    logic       digit_ready;
    logic       clear;
    logic       match;
    logic       fail;
    logic       locked_out;
    logic [1:0] fail_cnt;
    logic [2:0] digit_cnt;

    password_lock #(
        .DIGIT_W        (3),
        .LEN            (4),
        .PASSWORD       (12'o5273),
        .MAX_FAIL       (3),
        .LOCK_CYCLES    (16),
        .TIMEOUT_CYCLES (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .digit_in    (digit_in),
        .digit_valid (digit_valid),
        .digit_ready (digit_ready),
        .clear       (clear),
        .match       (match),
        .fail        (fail),
        .locked_out  (locked_out),
        .fail_cnt    (fail_cnt),
        .digit_cnt   (digit_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit is_match;
        int fcnt;
        int at_cyc;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every result pulse must correspond to a queued expectation.
    always @(negedge clk) begin
        if (match || fail) begin
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_pulse: match=%0d fail=%0d with nothing expected (cycle %0d)",
                         match, fail, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("pulse_match", int'(match), int'(e.is_match));
                chk("pulse_fail", int'(fail), int'(!e.is_match));
                chk("pulse_fail_cnt", int'(fail_cnt), e.fcnt);
                chk("pulse_cycle", cyc, e.at_cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_match"}, int'(match), 0);
        chk({tag, "_fail"}, int'(fail), 0);
        chk({tag, "_locked_out"}, int'(locked_out), 0);
        chk({tag, "_fail_cnt"}, int'(fail_cnt), 0);
        chk({tag, "_digit_cnt"}, int'(digit_cnt), 0);
        chk({tag, "_digit_ready"}, int'(digit_ready), 1);
    endtask

    task automatic send_digit(input logic [2:0] d);
        digit_valid = 1'b1;
        digit_in    = d;
        step();
        digit_valid = 1'b0;
    endtask

    // Four back-to-back digits, then the single CHECK cycle.
    task automatic enter(input logic [11:0] code, input bit exp_match,
                         input int exp_fcnt, input bit exp_lock);
        for (int i = 0; i < 4; i++) begin
            digit_valid = 1'b1;
            digit_in    = code[(3-i)*3 +: 3];
            step();
        end
        digit_valid = 1'b0;
        q.push_back('{exp_match, exp_fcnt, cyc + 1});
        chk("ready_in_check", int'(digit_ready), 0);
        step();
        chk("ready_after_check", int'(digit_ready), exp_lock ? 0 : 1);
        chk("locked_after_check", int'(locked_out), exp_lock ? 1 : 0);
        chk("fail_cnt_after_check", int'(fail_cnt), exp_fcnt);
        chk("digit_cnt_after_check", int'(digit_cnt), 0);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_lock;

        rst_n       = 1'b0;
        digit_in    = '0;
        digit_valid = 1'b0;
        clear       = 1'b0;
        step();
        step();
        check_reset_values("reset");
        rst_n = 1'b1;

        // Correct entry straight after reset, then wrong/right pair.
        enter(12'o5273, 1'b1, 0, 1'b0);
        enter(12'o5274, 1'b0, 1, 1'b0);
        enter(12'o5273, 1'b1, 0, 1'b0);

        // Three failures in a row: lockout for 16 cycles, inputs ignored.
        enter(12'o5274, 1'b0, 1, 1'b0);
        enter(12'o1111, 1'b0, 2, 1'b0);
        enter(12'o0000, 1'b0, 3, 1'b1);
        digit_valid = 1'b1;
        digit_in    = 3'd5;
        clear       = 1'b1;
        n_lock      = 0;
        for (int i = 0; i < 40; i++) begin
            if (!locked_out) break;
            n_lock++;
            if (digit_cnt != 0) chk("digit_cnt_in_lockout", int'(digit_cnt), 0);
            step();
        end
        digit_valid = 1'b0;
        clear       = 1'b0;
        chk("lockout_length", n_lock, 16);
        chk("fail_cnt_after_lockout", int'(fail_cnt), 0);
        chk("ready_after_lockout", int'(digit_ready), 1);
        chk("digit_cnt_after_lockout", int'(digit_cnt), 0);
        enter(12'o5273, 1'b1, 0, 1'b0);

        // Clear with a simultaneous digit: clear wins, no failure counted.
        send_digit(3'd5);
        send_digit(3'd2);
        chk("digit_cnt_partial", int'(digit_cnt), 2);
        digit_valid = 1'b1;
        digit_in    = 3'd7;
        clear       = 1'b1;
        step();
        digit_valid = 1'b0;
        clear       = 1'b0;
        chk("digit_cnt_after_clear", int'(digit_cnt), 0);
        chk("fail_cnt_after_clear", int'(fail_cnt), 0);
        step();
        enter(12'o5273, 1'b1, 0, 1'b0);

        // Reset mid-entry with a non-zero failure count.
        enter(12'o7777, 1'b0, 1, 1'b0);
        send_digit(3'd5);
        send_digit(3'd2);
        rst_n = 1'b0;
        step();
        check_reset_values("rst_mid_entry");
        rst_n = 1'b1;
        step();

        // Reset mid-lockout.
        enter(12'o0001, 1'b0, 1, 1'b0);
        enter(12'o0002, 1'b0, 2, 1'b0);
        enter(12'o0003, 1'b0, 3, 1'b1);
        for (int i = 0; i < 5; i++) step();
        chk("locked_before_reset", int'(locked_out), 1);
        rst_n = 1'b0;
        step();
        check_reset_values("rst_mid_lockout");
        rst_n = 1'b1;
        step();
        enter(12'o5273, 1'b1, 0, 1'b0);

        // Idle entry: one digit, then 32 cycles with nothing accepted.
`ifdef PWD_TIMEOUT_EN
        send_digit(3'd5);
        // Accepted at cycle a; timer expires after 32 idle cycles, CHECK
        // follows, so the fail pulse lands at cycle a+33.
        q.push_back('{1'b0, 1, cyc + 33});
        for (int i = 0; i < 40; i++) step();
        chk("fail_cnt_after_timeout", int'(fail_cnt), 1);
        chk("digit_cnt_after_timeout", int'(digit_cnt), 0);
`else
        send_digit(3'd5);
        for (int i = 0; i < 40; i++) step();
        chk("digit_cnt_no_timeout", int'(digit_cnt), 1);
        chk("fail_cnt_no_timeout", int'(fail_cnt), 0);
        clear = 1'b1;
        step();
        clear = 1'b0;
`endif

        for (int i = 0; i < 4; i++) step();
        chk("scoreboard_drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
